// File: rtl/lsu_mem_bridge.sv
// lsu_mem_bridge
// Load/store unit bridging the single-cycle RV32I core data port to a
// wait-state data memory. A core request becomes one word-aligned memory
// transaction with byte enables. Load data comes back sign- or zero-extended,
// and the core is stalled until the transaction completes.
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   req_*             core request (valid, we, funct3, byte addr, store data)
//   stall             core holds PC / regfile write while high
//   resp_valid        one-cycle completion pulse with resp_rdata / resp_err
//   mem_*             memory request, held stable until mem_ack
//
// Parameters
//   TIMEOUT           BUSY cycles without mem_ack before abort (0 = never)
//   AW                address width
//
// Build option
//   LSU_MISALIGN_EN   when defined, misaligned half/word accesses are
//                     faulted without touching memory; when undefined the
//                     low address bits below the access size are ignored.
//
// state | meaning
// IDLE  | waiting for a core request
// BUSY  | memory request outstanding, waiting for mem_ack or timeout
// RESP  | resp_valid pulse, core advances this cycle

module lsu_mem_bridge #(
    parameter int TIMEOUT = 255,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          stall,
    output logic          resp_valid,
    output logic [31:0]   resp_rdata,
    output logic          resp_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [3:0]    mem_be,
    output logic [31:0]   mem_wdata,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      f3_q, f3_d;
    logic [1:0]      addr_lo_q, addr_lo_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]      mem_be_q, mem_be_d;
    logic [31:0]     mem_wdata_q, mem_wdata_d;
    logic            resp_valid_q, resp_valid_d;
    logic [31:0]     resp_rdata_q, resp_rdata_d;
    logic            resp_err_q, resp_err_d;

    logic            legal;
    logic            misal;
    logic [3:0]      be_new;
    logic [31:0]     wdata_new;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_ext;
    logic            tmo_hit;

    // Request decode: legality, alignment, byte enables, replicated store data.
    always_comb begin
        if (req_we) begin
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) ||
                    (req_funct3 == 3'b010);
        end else begin
            legal = !((req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                      (req_funct3 == 3'b111));
        end

`ifdef LSU_MISALIGN_EN
        misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
        misal = 1'b0;
`endif

        be_new    = 4'b1111;
        wdata_new = req_wdata;
        if (req_we) begin
            case (req_funct3[1:0])
                2'b00: begin
                    be_new    = 4'b0001 << req_addr[1:0];
                    wdata_new = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    be_new    = req_addr[1] ? 4'b1100 : 4'b0011;
                    wdata_new = {2{req_wdata[15:0]}};
                end
                default: begin
                    be_new    = 4'b1111;
                    wdata_new = req_wdata;
                end
            endcase
        end
    end

    // Load extraction uses the lane captured at request time.
    always_comb begin
        case (addr_lo_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'd0, ld_byte};
            3'b101:  ld_ext = {16'd0, ld_half};
            default: ld_ext = mem_rdata;
        endcase
    end

    // Counter holds the number of BUSY cycles already spent without ack,
    // so the abort fires in the TIMEOUT-th BUSY cycle.
    assign tmo_hit = (TIMEOUT > 0) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        f3_d         = f3_q;
        addr_lo_d    = addr_lo_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (!legal || misal) begin
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'd0;
                        state_d      = S_RESP;
                    end else begin
                        f3_d        = req_funct3;
                        addr_lo_d   = req_addr[1:0];
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[AW-1:2], 2'b00};
                        mem_be_d    = be_new;
                        mem_wdata_d = wdata_new;
                        cnt_d       = '0;
                        state_d     = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (mem_ack) begin
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = mem_we_q ? 32'd0 : ld_ext;
                    cnt_d        = '0;
                    state_d      = S_RESP;
                end else if (tmo_hit) begin
                    mem_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_rdata_d = 32'd0;
                    cnt_d        = '0;
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                resp_valid_d = 1'b0;
                resp_err_d   = 1'b0;
                resp_rdata_d = 32'd0;
                cnt_d        = '0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            f3_q         <= 3'd0;
            addr_lo_q    <= 2'd0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            f3_q         <= f3_d;
            addr_lo_q    <= addr_lo_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign stall      = req_valid & ~resp_valid_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Testbench for lsu_mem_bridge (TIMEOUT=4). Directed cases followed by
// randomized transactions; expectations come from a behavioural model of
// the access rules.

module tb_lsu_mem_bridge;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    lsu_mem_bridge #(.TIMEOUT(TMO), .AW(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic bit m_legal(input logic we, input logic [2:0] f3);
        if (we) return (f3 <= 3'd2);
        return !(f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    endfunction

    function automatic bit m_misal(input logic [2:0] f3, input logic [31:0] a);
`ifdef LSU_MISALIGN_EN
        if (f3[1:0] == 2'b01) return (a % 2) != 0;
        if (f3[1:0] == 2'b10) return (a % 4) != 0;
`endif
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
        if (!we) return 4'hF;
        if (f3 == 3'd0) return 4'(1 << (a % 4));
        if (f3 == 3'd1) return 4'(3 << ((a / 2) % 2 * 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] b, h;
        b = wd % 256;
        h = wd % 65536;
        if (f3 == 3'd0) return b * 32'h01010101;
        if (f3 == 3'd1) return h * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] b, h;
        b = (rd >> (8 * (a % 4))) % 256;
        h = (rd >> (16 * ((a / 2) % 2))) % 65536;
        case (f3)
            3'd0: return (b >= 128) ? b - 256 : b;
            3'd1: return (h >= 32768) ? h - 65536 : h;
            3'd4: return b;
            3'd5: return h;
            default: return rd;
        endcase
    endfunction

    // One transaction starting in IDLE right after a clock edge. ack_wait is
    // the number of BUSY cycles without ack before mem_ack is given.
    task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rd, input int ack_wait);
        bit early, done, ack_now;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        mem_rdata  = rd;
        mem_ack    = 1'b0;
        #1;
        chk("c0_stall", 32'(stall), 32'd1);
        chk("c0_mem_req", 32'(mem_req), 32'd0);
        early = !m_legal(we, f3) || m_misal(f3, a);
        step();
        if (early) begin
            chk("err_resp_valid", 32'(resp_valid), 32'd1);
            chk("err_resp_err", 32'(resp_err), 32'd1);
            chk("err_rdata", resp_rdata, 32'd0);
            chk("err_mem_req", 32'(mem_req), 32'd0);
            chk("err_stall", 32'(stall), 32'd0);
        end else begin
            done = 1'b0;
            for (int k = 1; k <= TMO + 1 && !done; k++) begin
                chk("busy_mem_req", 32'(mem_req), 32'd1);
                chk("busy_mem_we", 32'(mem_we), 32'(we));
                chk("busy_mem_addr", mem_addr, a & 32'hFFFF_FFFC);
                chk("busy_mem_be", 32'(mem_be), 32'(m_be(we, f3, a)));
                if (we) chk("busy_mem_wdata", mem_wdata, m_wdata(f3, wd));
                chk("busy_resp_valid", 32'(resp_valid), 32'd0);
                chk("busy_stall", 32'(stall), 32'd1);
                ack_now = (ack_wait == k - 1);
                mem_ack = ack_now;
                step();
                mem_ack = 1'b0;
                if (ack_now || k == TMO) begin
                    chk("resp_valid", 32'(resp_valid), 32'd1);
                    chk("resp_err", 32'(resp_err), ack_now ? 32'd0 : 32'd1);
                    chk("resp_rdata", resp_rdata,
                        (ack_now && !we) ? m_load(f3, a, rd) : 32'd0);
                    chk("resp_mem_req", 32'(mem_req), 32'd0);
                    chk("resp_stall", 32'(stall), 32'd0);
                    done = 1'b1;
                end
            end
            if (!done) chk("resp_within_bound", 32'd0, 32'd1);
        end
        step();
        req_valid = 1'b0;
        #1;
        chk("post_resp_valid", 32'(resp_valid), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'd0;
        #2;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();

        // Directed cases
        txn(1'b1, 3'd2, 32'h64, 32'h19, 32'h0, 3);              // sw, 3 wait cycles
        txn(1'b1, 3'd0, 32'h61, 32'hAB, 32'h0, 0);              // sb, immediate ack
        txn(1'b0, 3'd0, 32'h62, 32'h0, 32'h1280FF34, 1);        // lb
        txn(1'b0, 3'd4, 32'h62, 32'h0, 32'h1280FF34, 0);        // lbu
        txn(1'b0, 3'd5, 32'h62, 32'h0, 32'h1280FF34, 2);        // lhu
        txn(1'b0, 3'd1, 32'h62, 32'h0, 32'h1280FF34, 0);        // lh
        txn(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 99);      // timeout
        txn(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, TMO - 1); // ack on last cycle
        txn(1'b1, 3'd1, 32'h73, 32'hCAFE1234, 32'h0, 0);        // sh at odd address
        txn(1'b0, 3'd2, 32'h66, 32'h0, 32'h55AA33CC, 0);        // lw misaligned
        txn(1'b0, 3'd3, 32'h40, 32'h0, 32'h0, 0);               // illegal load
        txn(1'b1, 3'd4, 32'h40, 32'h0, 32'h0, 0);               // illegal store

        // mem_ack while idle is ignored
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("idle_ack_mem_req", 32'(mem_req), 32'd0);
        chk("idle_ack_resp_valid", 32'(resp_valid), 32'd0);

        // Reset in the middle of BUSY
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h200;
        step();
        step();
        chk("pre_rst_mem_req", 32'(mem_req), 32'd1);
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
        chk("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        step();
        reset = 1'b0;
        step();
        chk("after_rst_resp_valid", 32'(resp_valid), 32'd0);
        txn(1'b0, 3'd2, 32'h204, 32'h0, 32'h01234567, 1);

        // Randomized transactions
        for (int i = 0; i < 60; i++) begin
            txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                $urandom, $urandom, int'($urandom_range(0, TMO + 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_bridge.md
Name: lsu_mem_bridge

Overview:
Load/store unit between the single-cycle RV32I core's data port and a wait-state data memory. It turns a core request (address, funct3, store data) into a word-aligned memory transaction with byte enables. Load data is sign- or zero-extended, and the core is stalled until the memory acks. This adds lb/lh/lbu/lhu/sb/sh support and allows memories slower than one cycle.

Parameters:
TIMEOUT, 255, max cycles in BUSY waiting for mem_ack before abort; 0 = no timeout
AW, 32, address width

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
req_valid  in  1  core has a load/store this cycle (held until resp_valid)
req_we  in  1  1 = store, 0 = load
req_funct3  in  3  instruction funct3 (size/sign)
req_addr  in  AW  byte address (ALUResult)
req_wdata  in  32  store data (rs2)
stall  out  1  core must hold PC/regfile write
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data, valid with resp_valid
resp_err  out  1  access fault, valid with resp_valid
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  memory write
mem_addr  out  AW  word address, bits [1:0] = 0
mem_be  out  4  byte enables
mem_wdata  out  32  lane-replicated write data
mem_ack  in  1  memory done; rdata valid same cycle
mem_rdata  in  32  memory read word

Behaviour:
- FSM states: IDLE, BUSY, RESP. Reset forces IDLE immediately (async).
- Reset values: stall 0, resp_valid 0, resp_rdata 0, resp_err 0, mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0, timeout counter 0.
- IDLE, req_valid=1, funct3 legal:
  - Register we, funct3, addr[1:0], mem_addr={addr[AW-1:2],2'b00}, mem_be, mem_wdata.
  - Go to BUSY.
- IDLE, req_valid=1, funct3 illegal (load: 011/110/111; store: anything other than 000/001/010): go to RESP with resp_err=1 and no memory access.
- BUSY:
  - mem_req=1 and all mem_* outputs held stable.
  - On mem_ack: capture extended data and go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT (TIMEOUT>0), go to RESP with resp_err=1, resp_rdata=0, and drop mem_req.
  - mem_ack and timeout in the same cycle: ack wins, no error.
- RESP: resp_valid=1 for exactly one cycle, then IDLE. Counter cleared.
- stall = req_valid & ~resp_valid (combinational). The core advances in the RESP cycle.
- Latency: request seen in IDLE at cycle 0, mem_req from cycle 1. Ack at cycle N≥1 gives resp_valid at N+1. Minimum 2 stall cycles.
- Back-to-back: req_valid high in IDLE the cycle after RESP is a new request, accepted immediately.
- mem_ack outside BUSY is ignored.
- Byte enables:
  - sb: 4'b0001<<addr[1:0]
  - sh: 4'b0011<<{addr[1],1'b0}
  - sw: 4'b1111
  - loads: 4'b1111
- mem_wdata: sb {4{wdata[7:0]}}, sh {2{wdata[15:0]}}, sw wdata.
- Load extract:
  - Byte = mem_rdata[8*addr[1:0] +: 8].
  - Half = mem_rdata[16*addr[1] +: 16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
  - Store responses return resp_rdata=0.
- Reset mid-BUSY: mem_req drops asynchronously. The memory must tolerate an abandoned request. No response is issued.
- req_valid deasserted by the core during BUSY: the transaction still completes. resp_valid still pulses (core was reset or flushed; result ignored).

Optional Feature:
LSU_MISALIGN_EN
- Defined: halfword with addr[0]=1 or word with addr[1:0]≠0 gets no memory access. Goes IDLE→RESP with resp_err=1, resp_rdata=0.
- Undefined: low address bits below the access size are ignored; sh at 0x...3 writes bytes 2-3; lw at 0x...6 reads word 0x...4; resp_err never set for alignment.

Test Plan:
- sw addr 0x64 wdata 0x00000019, ack after 3 wait cycles → mem_req cycles 1-4 with be=1111, addr=0x64; resp_valid at cycle 5, resp_err=0, stall high cycles 0-4.
- sb addr 0x61 wdata 0x000000AB, immediate ack → be=0010, mem_wdata=0xABABABAB, addr=0x60.
- lb addr 0x62 with mem_rdata 0x1280FF34 → resp_rdata 0xFFFFFF80; same with lbu → 0x00000080; lhu addr 0x62 → 0x00001280; lh → 0x00001280.
- Load with no ack, TIMEOUT=4 → mem_req for 4 cycles then drops; resp_valid with resp_err=1, rdata 0. Repeat with ack on the 4th cycle → no error.
- Reset asserted during BUSY → mem_req, stall-state and resp_valid go 0 same cycle; next request after reset completes normally.
- LSU_MISALIGN_EN defined: lw addr 0x66 → no mem_req, resp_valid next cycle with resp_err=1. Undefined: mem_addr 0x64, be 1111, resp_err 0.
